fi_injector: RTL and testbench

//  Fault-injection actuator: the write side of the signal-of-interest (SOI) channel.

---
 rtl/fi_pkg.sv | 31 +++
 rtl/fi_countdown.sv | 22 ++
 rtl/fi_injector.sv | 133 +++++++++++++
 tb/tb_fi_injector.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fi_pkg.sv
// Shared types, default widths and the fault overlay helper for the fault-injection actuator.
package fi_pkg;

  typedef enum logic [1:0] {
    STUCK0    = 2'd0,
    STUCK1    = 2'd1,
    FLIP_ONCE = 2'd2,
    FLIP_CONT = 2'd3
  } fi_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    INJECT = 2'd2,
    DONE   = 2'd3
  } fi_state_e;

  localparam int FI_N_SOI = 3;
  localparam int FI_DLY_W = 16;
  localparam int FI_DUR_W = 8;

  // Value a faulted bit takes under the given mode.
  function automatic logic fi_overlay(input fi_mode_e m, input logic b);
    case (m)
      STUCK0:  return 1'b0;
      STUCK1:  return 1'b1;
      default: return ~b;
    endcase
  endfunction

endpackage

// File: rtl/fi_countdown.sv
// Loadable down-counter that saturates at zero; expire flags the last counted cycle (value==1).
module fi_countdown #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  always_ff @(posedge clk) begin
    if (reset)                   value <= '0;
    else if (load)               value <= load_val;
    else if (en && value != '0)  value <= value - 1'b1;
  end

  assign expire = (value == W'(1));

endmodule

// File: rtl/fi_injector.sv
// Fault-injection actuator: overlays a delayed stuck-at / bit-flip fault on one SOI bit.
// Optional FI_INJECT_LOG_EN adds a cycle counter and a log report on INJECT entry.
module fi_injector
  import fi_pkg::*;
#(
  parameter  int N_SOI = FI_N_SOI,
  parameter  int DLY_W = FI_DLY_W,
  parameter  int DUR_W = FI_DUR_W,
  localparam int TGT_W = (N_SOI > 1) ? $clog2(N_SOI) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [TGT_W-1:0] cmd_target,
  input  logic [1:0]       cmd_mode,
  input  logic [DLY_W-1:0] cmd_delay,
  input  logic [DUR_W-1:0] cmd_duration,
  input  logic             abort,
  input  logic [N_SOI-1:0] soi_in,
  output logic [N_SOI-1:0] soi_out,
  output logic             inj_active,
  output logic             done,
  output logic             cmd_err
);

  fi_state_e        state, state_n;
  fi_mode_e         mode_q;
  logic [TGT_W-1:0] tgt_q;
  logic             accept, tgt_ok, start;
  logic             dly_load, dly_en, dly_expire;
  logic             dur_load, dur_en, dur_expire;
  logic [DLY_W-1:0] dly_val;
  logic [DUR_W-1:0] dur_val;

  assign cmd_ready  = (state == IDLE);
  assign accept     = cmd_valid && cmd_ready && !abort;
  assign tgt_ok     = 32'(cmd_target) < 32'(N_SOI);
  assign start      = accept && tgt_ok;
  assign inj_active = (state == INJECT);
  assign done       = (state == DONE);

  fi_countdown #(.W(DLY_W)) u_dly (
    .clk      (clk),
    .reset    (reset),
    .load     (dly_load),
    .en       (dly_en),
    .load_val (cmd_delay),
    .value    (dly_val),
    .expire   (dly_expire)
  );

  // Duration is loaded at accept and held untouched through DELAY.
  fi_countdown #(.W(DUR_W)) u_dur (
    .clk      (clk),
    .reset    (reset),
    .load     (dur_load),
    .en       (dur_en),
    .load_val (cmd_duration),
    .value    (dur_val),
    .expire   (dur_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mode_q  <= STUCK0;
      tgt_q   <= '0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_n;
      cmd_err <= accept && !tgt_ok;
      if (start) begin
        mode_q <= fi_mode_e'(cmd_mode);
        tgt_q  <= cmd_target;
      end
    end
  end

  always_comb begin
    state_n  = state;
    dly_load = 1'b0;
    dly_en   = 1'b0;
    dur_load = 1'b0;
    dur_en   = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dly_load = 1'b1;
            dur_load = 1'b1;
            state_n  = (cmd_delay == '0) ? INJECT : DELAY;
          end
        end
        DELAY: begin
          if (dly_expire) state_n = INJECT;
          else            dly_en  = 1'b1;
        end
        INJECT: begin
          // A zero duration never expires, so the fault holds until abort.
          if (mode_q == FLIP_ONCE || dur_expire) state_n = DONE;
          else                                   dur_en  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_SOI; i++) begin : g_soi
    assign soi_out[i] = (inj_active && tgt_q == TGT_W'(i)) ? fi_overlay(mode_q, soi_in[i])
                                                           : soi_in[i];
  end

`ifdef FI_INJECT_LOG_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state != INJECT && state_n == INJECT)
        $display("fiLogInjection target=%0d mode=%0d cycle=%0d",
                 int'(state == IDLE ? cmd_target : tgt_q),
                 int'(state == IDLE ? fi_mode_e'(cmd_mode) : mode_q),
                 int'(cycle_cnt));
    end
  end
`endif

endmodule

// File: tb/tb_fi_injector.sv
// Directed self-checking bench for fi_injector (default N_SOI=3, DLY_W=16, DUR_W=8).
module tb_fi_injector;
  import fi_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, abort, inj_active, done, cmd_err;
  logic [1:0]  cmd_target, cmd_mode;
  logic [15:0] cmd_delay;
  logic [7:0]  cmd_duration;
  logic [2:0]  soi_in, soi_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fi_injector dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_target   (cmd_target),
    .cmd_mode     (cmd_mode),
    .cmd_delay    (cmd_delay),
    .cmd_duration (cmd_duration),
    .abort        (abort),
    .soi_in       (soi_in),
    .soi_out      (soi_out),
    .inj_active   (inj_active),
    .done         (done),
    .cmd_err      (cmd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for exactly one cycle; returns in cycle 1 after the accept edge.
  task automatic send(input logic [1:0] tgt, input fi_mode_e m, input logic [15:0] dly,
                      input logic [7:0] dur);
    cmd_target   = tgt;
    cmd_mode     = m;
    cmd_delay    = dly;
    cmd_duration = dur;
    cmd_valid    = 1'b1;
    tick();
    cmd_valid    = 1'b0;
  endtask

  initial begin
    int inj_cnt, done_cnt, first, done_at, bad;
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_target = '0; cmd_mode = '0; cmd_delay = '0; cmd_duration = '0;
    soi_in = 3'b101;
    tick(); tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_inj",   inj_active, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   cmd_err, 0);
    chk("rst_soi",   soi_out, 3'b101);
    reset = 1'b0;
    tick();

    // STUCK1 on bit 1, no delay, 3 cycles
    soi_in = 3'b000;
    send(2'd1, STUCK1, 16'd0, 8'd3);
    for (int c = 1; c <= 3; c++) begin
      chk("t1_soi", soi_out, 3'b010);
      chk("t1_inj", inj_active, 1);
      chk("t1_done_early", done, 0);
      tick();
    end
    chk("t1_soi_after", soi_out, 3'b000);
    chk("t1_done", done, 1);
    chk("t1_ready_done", cmd_ready, 0);
    tick();
    chk("t1_done_clr", done, 0);
    chk("t1_ready", cmd_ready, 1);

    // FLIP_ONCE on bit 0 after 5 cycles; duration ignored
    soi_in = 3'b101;
    send(2'd0, FLIP_ONCE, 16'd5, 8'd9);
    bad = 0;
    for (int c = 1; c <= 5; c++) begin
      if (soi_out !== 3'b101 || inj_active !== 1'b0) bad++;
      tick();
    end
    chk("t2_delay_clean", bad, 0);
    chk("t2_soi", soi_out, 3'b100);
    chk("t2_inj", inj_active, 1);
    tick();
    chk("t2_soi_after", soi_out, 3'b101);
    chk("t2_done", done, 1);
    tick();
    chk("t2_ready", cmd_ready, 1);

    // STUCK0 on bit 2 with duration 0: held until abort
    soi_in = 3'b111;
    send(2'd2, STUCK0, 16'd0, 8'd0);
    bad = 0;
    for (int c = 1; c <= 100; c++) begin
      if (soi_out !== 3'b011 || done !== 1'b0) bad++;
      if (c < 100) tick();
    end
    chk("t3_hold", bad, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_soi_abort", soi_out, 3'b111);
    chk("t3_inj_abort", inj_active, 0);
    chk("t3_no_done", done, 0);
    chk("t3_ready", cmd_ready, 1);
    tick();
    chk("t3_no_done2", done, 0);

    // Out-of-range target: rejected with cmd_err, no fault
    soi_in = 3'b010;
    send(2'd3, STUCK1, 16'd0, 8'd1);
    chk("t4_err", cmd_err, 1);
    chk("t4_ready", cmd_ready, 1);
    chk("t4_soi", soi_out, 3'b010);
    chk("t4_inj", inj_active, 0);
    tick();
    chk("t4_err_clr", cmd_err, 0);

    // abort beats cmd_valid in IDLE
    abort = 1'b1;
    send(2'd0, STUCK1, 16'd0, 8'd2);
    abort = 1'b0;
    chk("t5_no_accept_inj", inj_active, 0);
    chk("t5_no_accept_ready", cmd_ready, 1);
    tick();
    chk("t5_no_accept_done", done, 0);

    // Reset during DELAY drops the command
    soi_in = 3'b000;
    send(2'd0, STUCK1, 16'd10, 8'd2);
    tick(); tick();
    chk("t5_in_delay", cmd_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_ready", cmd_ready, 1);
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      if (inj_active !== 1'b0 || done !== 1'b0 || soi_out !== 3'b000) bad++;
      tick();
    end
    chk("t5_rst_no_fault", bad, 0);

    // Max delay and max duration counted exactly
    soi_in = 3'b000;
    send(2'd2, FLIP_CONT, 16'hFFFF, 8'd255);
    inj_cnt = 0; done_cnt = 0; first = -1; done_at = -1; bad = 0;
    for (int c = 1; c <= 66000; c++) begin
      if (inj_active === 1'b1) begin
        inj_cnt++;
        if (first < 0) first = c;
        if (soi_out !== 3'b100) bad++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      tick();
    end
    chk("t6_first", first, 65536);
    chk("t6_len", inj_cnt, 255);
    chk("t6_soi", bad, 0);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_done_at", done_at, 65791);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
